keypad_scan: RTL

Matrix-keypad scanner that drives a 4x4 key matrix and produces the 16-bit one-hot key vector consumed by the keypad decode/display logic. It strobes one column low at a time, samples the rows, debounces whole scan frames, and presents a stable one-hot code that is held while the key is down and returns to zero on release. A one-cycle change strobe accompanies every update.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/keypad_debounce.sv | 57 +++++
 rtl/keypad_scan.sv | 68 ++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes shared by the keypad scanner and the decode/display
// logic. A code is the one-hot vector bit (4*col_idx + row_idx).
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int KEY_W    = NUM_COLS * NUM_ROWS;

  localparam logic [KEY_W-1:0] NO_KEY        = 16'h0000;
  localparam logic [KEY_W-1:0] KEY_ENTER     = 16'h0001;
  localparam logic [KEY_W-1:0] KEY_0         = 16'h0008;
  localparam logic [KEY_W-1:0] KEY_1         = 16'h0080;
  localparam logic [KEY_W-1:0] KEY_2         = 16'h0040;
  localparam logic [KEY_W-1:0] KEY_3         = 16'h0020;
  localparam logic [KEY_W-1:0] KEY_4         = 16'h0800;
  localparam logic [KEY_W-1:0] KEY_5         = 16'h0400;
  localparam logic [KEY_W-1:0] KEY_6         = 16'h0200;
  localparam logic [KEY_W-1:0] KEY_7         = 16'h8000;
  localparam logic [KEY_W-1:0] KEY_8         = 16'h4000;
  localparam logic [KEY_W-1:0] KEY_9         = 16'h2000;
  localparam logic [KEY_W-1:0] KEY_CLR_ALL   = 16'h0100;
  localparam logic [KEY_W-1:0] KEY_CLR_ENTRY = 16'h1000;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: whole-frame debouncer.
//   clk, rst       clock, synchronous active-high reset
//   frame_vld      one-cycle strobe, a complete raw frame is on 'frame'
//   frame          16-bit raw key frame (1 = pressed)
//   onehot         debounced key code, NO_KEY for none / multi-key
//   key_event      one-cycle pulse whenever onehot changes
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_vld,
  input  logic [KEY_W-1:0] frame,
  output logic [KEY_W-1:0] onehot,
  output logic             key_event
);

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  logic [KEY_W-1:0] prev;
  logic [3:0]       stab, stab_nxt;
  logic [KEY_W-1:0] cand;

  always_comb begin
    stab_nxt = stab;
    if (frame == prev) begin
      if (stab < DF) stab_nxt = stab + 4'd1;
    end else begin
      stab_nxt = 4'd1;
    end
    // Ghost / multi-key frames collapse to no key.
    cand = is_onehot(frame) ? frame : NO_KEY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '0;
      stab      <= '0;
      onehot    <= NO_KEY;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (frame_vld) begin
        prev <= frame;
        stab <= stab_nxt;
        // Saturated counter re-evaluates every frame; only a real change updates.
        if (stab_nxt == DF && cand != onehot) begin
          onehot    <= cand;
          key_event <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner.
//   clk, rst   clock, synchronous active-high reset
//   row        matrix rows, async, active-low
//   col        matrix columns, active-low, one low at a time
//   onehot     debounced one-hot key code (bit 4*col+row)
//   key_event  one-cycle pulse on every onehot change
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    onehot,
  output logic                key_event
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]       cnt;
  logic [1:0]          col_idx;
  logic [NUM_ROWS-1:0] row_m, row_s;
  logic [11:0]         raw;       // columns 0..2; column 3 feeds the frame directly
  logic                sample;
  logic                frame_vld;
  logic [KEY_W-1:0]    frame;

  assign sample    = (cnt == CW'(SCAN_DIV - 1));
  assign frame_vld = sample && (col_idx == 2'd3);
  assign frame     = {~row_s, raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      row_m   <= 4'hF;
      row_s   <= 4'hF;
      cnt     <= '0;
      col_idx <= '0;
      col     <= 4'b1110;
      raw     <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      if (sample) begin
        // Sample at end of dwell; the column moves on the same edge, so rows
        // had SCAN_DIV-1 cycles (less the synchronizer) to settle.
        cnt     <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[2:0], col[3]};
        if (col_idx != 2'd3) raw[{col_idx, 2'b00} +: 4] <= ~row_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
    .clk       (clk),
    .rst       (rst),
    .frame_vld (frame_vld),
    .frame     (frame),
    .onehot    (onehot),
    .key_event (key_event)
  );

endmodule
